tape_dumper: RTL and testbench
==============================

# tape_dumper

Read-out engine for the Turing machine's 1-bit tape RAM. After the machine halts, it reads a contiguous span of tape cells and packs them LSB-first into WORD_WIDTH-bit words. Words go out over a valid/ready stream, so a host can capture the final tape. It owns the tape RAM read address while busy; the machine must be held in reset or stalled while it runs.

## Interface
- ADDR_WIDTH, 14: tape RAM address width, matching the tape memory size.
- WORD_WIDTH, 8: packed output word width, 1..32.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first tape cell; sampled with start.
- length  in  ADDR_WIDTH+1  number of cells to read; sampled with start.
- busy  out  1  high in every state except IDLE.
- ram_addr  out  ADDR_WIDTH  tape RAM read address. The RAM reads synchronously, so data appears the cycle after the address is presented.
- ram_rdata  in  1  tape RAM read data.
- out_data  out  WORD_WIDTH  packed word.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  marks the final word; qualified by out_valid.
- done  out  1  one-cycle pulse after the final word is accepted, or after a zero-length request.

## Operation
- States: IDLE, FETCH, SAMPLE, SEND, DONE.
- IDLE
  - On start: latch base_addr, set idx=0, and latch len = min(length, 2^ADDR_WIDTH).
  - If len==0, go to DONE; otherwise go to FETCH.
- FETCH: drive ram_addr = (base + idx) mod 2^ADDR_WIDTH; go to SAMPLE.
- SAMPLE
  - Write ram_rdata into shift-register bit (idx mod WORD_WIDTH); then idx += 1.
  - If the word is full or idx==len, go to SEND; otherwise go to FETCH.
- SEND
  - Hold out_valid=1 with out_data stable until out_ready=1.
  - out_last=1 when idx==len.
  - On handshake, clear the word register; go to DONE if last, otherwise FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- Packing: tape cell i lands in bit (i mod WORD_WIDTH) of word floor(i/WORD_WIDTH). Unused upper bits of the final partial word are 0.
- Address wrap: base+idx is taken modulo 2^ADDR_WIDTH.
  - Example: base=16382, len=4 reads cells 16382, 16383, 0, 1.
- start while busy is ignored; no queueing.
- length > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset values: busy=0, ram_addr=0, out_data=0, out_valid=0, out_last=0, done=0, state=IDLE.
- rst overrides everything and aborts mid-operation:
  - state returns to IDLE next edge, with all outputs at reset values.
  - No done pulse is issued and a pending word is discarded.
- Throughput: each cell costs 2 cycles (FETCH + SAMPLE).
- Reference timeline: start is sampled at edge 0 and busy=1 from cycle 1.
  - Bit k (0-based within a word) is fetched in cycle 2k+1 and sampled at the end of cycle 2k+2.
  - out_valid is first high in cycle 2n+1, where n is the number of bits in the word. For WORD_WIDTH=8 and len>=8 that is cycle 17.
- Handshake:
  - The transfer occurs on the edge where out_valid & out_ready.
  - With out_ready held high, SEND lasts one cycle. The next word's first FETCH follows in the next cycle, so each full word takes 2*WORD_WIDTH+1 cycles.
- Completion:
  - done is high in the cycle after the last-word handshake. busy stays high through DONE.
  - busy=0 and start is accepted again from the following cycle.
- Zero length: start at edge 0 gives DONE in cycle 1 (done=1, busy=1) and IDLE in cycle 2. out_valid never asserts.
- No combinational path from out_ready to out_valid or out_data. All outputs are registered or decoded from state.

## Test plan
- **Reset defaults:** hold rst 3 cycles -> all outputs 0. Then pulse start with length=0 -> done=1 in cycle 1, no out_valid.
- **Full words, always ready:** tape cells 0..15 = 1,0,1,1,0,0,0,1, 1,1,1,1,0,0,0,0; base=0, length=16, out_ready=1.
  - Expect words 0x8D then 0x0F; out_last only on 0x0F.
  - First out_valid in cycle 17; done one cycle after the second handshake.
- **Partial word and wrap:** base=16382, length=3, cells 16382=1, 16383=1, 0=1.
  - Expect one word 0x07 with out_last=1.
  - ram_addr sequence 16382, 16383, 0.
- **Backpressure:** length=8, out_ready low for 5 cycles after out_valid rises.
  - out_data and out_valid stay stable throughout; exactly one transfer; done follows.
- **Start while busy and reset mid-run:**
  - A second start during the run is ignored; the word count is unchanged.
  - rst during SAMPLE of word 2 gives IDLE next cycle, all outputs 0, no done.
  - A fresh start afterwards completes normally.

Source files
------------

// File: rtl/tape_dumper_if.sv
// Valid/ready word stream carrying packed tape words from the dumper to the host.
interface tape_dumper_if #(
   parameter int WORD_WIDTH = 8
);
   logic [WORD_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/tape_dumper.sv
// Reads a span of the 1-bit tape RAM after halt and streams it out packed LSB-first
// into WORD_WIDTH-bit words; each cell takes a FETCH cycle and a SAMPLE cycle.
module tape_dumper #(
   parameter int ADDR_WIDTH = 14,
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic                  ram_rdata,
   tape_dumper_if.master         stream,
   output logic                  done
);
   localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam logic [BW-1:0]       LAST_BIT = BW'(WORD_WIDTH - 1);
   localparam logic [ADDR_WIDTH:0] LEN_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SAMPLE = 3'd2,
      SEND   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [ADDR_WIDTH:0]     idx_q, idx_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [WORD_WIDTH-1:0]   word_q, word_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         bit_q      <= '0;
         word_q     <= '0;
         ram_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         bit_q      <= bit_d;
         word_q     <= word_d;
         ram_addr_q <= ram_addr_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      idx_d      = idx_q;
      bit_d      = bit_q;
      word_d     = word_q;
      ram_addr_d = ram_addr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d = base_addr;
               idx_d  = '0;
               bit_d  = '0;
               word_d = '0;
               len_d  = length[ADDR_WIDTH] ? LEN_MAX : length;
               if (len_d == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            state_d = SAMPLE;
         end
         SAMPLE: begin
            word_d[bit_q] = ram_rdata;
            idx_d         = idx_q + (ADDR_WIDTH + 1)'(1);
            if ((bit_q == LAST_BIT) || (idx_d == len_q)) begin
               state_d = SEND;
               bit_d   = '0;
            end else begin
               state_d = FETCH;
               bit_d   = bit_q + BW'(1);
            end
         end
         SEND: begin
            if (stream.out_ready) begin
               word_d  = '0;
               state_d = (idx_q == len_q) ? DONE : FETCH;
            end else begin
               state_d = SEND;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // The RAM needs the address while FETCH is current, so it is loaded on entry.
      if (state_d == FETCH) begin
         ram_addr_d = base_d + idx_d[ADDR_WIDTH-1:0];
      end else begin
         ram_addr_d = ram_addr_q;
      end
   end

   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign ram_addr         = ram_addr_q;
   assign stream.out_data  = word_q;
   assign stream.out_valid = (state_q == SEND);
   assign stream.out_last  = (state_q == SEND) && (idx_q == len_q);
endmodule

// File: tb/tb_tape_dumper.sv
// Self-checking bench for tape_dumper: a queue-based word model built from the tape
// contents is checked against the output stream every cycle.
module tb_tape_dumper;
   localparam int AW    = 14;
   localparam int WW    = 8;
   localparam int CELLS = 16384;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy;
   logic [AW-1:0] ram_addr;
   logic          ram_rdata;
   logic          done;

   tape_dumper_if #(.WORD_WIDTH(WW)) sif ();

   tape_dumper #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_rdata (ram_rdata),
      .stream    (sif.master),
      .done      (done)
   );

   always #5 clk = ~clk;

   logic tape [0:CELLS-1];

   // Synchronous-read tape RAM model.
   always @(posedge clk) ram_rdata <= tape[ram_addr];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  cap_q[$];
   logic        done_armed = 1'b0;
   logic        zero_job   = 1'b0;
   int          done_count = 0;
   int          ready_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: cell i goes to bit i%WW of word i/WW; tail bits of a partial word stay 0.
   task automatic model_job(input int b, input int l);
      int         n;
      logic [7:0] w;
      n = (l > CELLS) ? CELLS : l;
      w = 8'h00;
      for (int i = 0; i < n; i++) begin
         w[i % WW] = tape[(b + i) % CELLS];
         if ((i % WW == WW - 1) || (i == n - 1)) begin
            exp_q.push_back(w);
            w = 8'h00;
         end
      end
      zero_job   = (n == 0);
      done_armed = 1'b1;
   endtask

   task automatic do_start(input int b, input int l, input bit modelled);
      @(posedge clk); #1;
      if (modelled) model_job(b, l);
      start     = 1'b1;
      base_addr = AW'(b);
      length    = (AW + 1)'(l);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int c0;
      bit got;
      c0  = done_count;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk); #1;
         if (done_count != c0) got = 1'b1;
      end
      chk(name, {31'd0, got}, 32'd1);
   endtask

   // Ready driver: 0 = always ready, 1 = random, 2 = driven by the test.
   initial begin
      sif.out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       sif.out_ready = 1'b1;
            1:       sif.out_ready = 1'($urandom_range(0, 1));
            default: sif.out_ready = sif.out_ready;
         endcase
      end
   end

   logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last_hs = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Compare process: stream vs model, stability under backpressure, done timing.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid   = 1'b0;
         prev_ready   = 1'b0;
         prev_last_hs = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", {31'd0, sif.out_valid}, 32'd1);
            chk("hold_data", {24'd0, sif.out_data}, {24'd0, prev_data});
         end
         if (sif.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               chk("out_data", {24'd0, sif.out_data}, {24'd0, exp_q[0]});
               chk("out_last", {31'd0, sif.out_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
               if (sif.out_ready) begin
                  cap_q.push_back(sif.out_data);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (done) begin
            chk("done_armed", {31'd0, done_armed}, 32'd1);
            chk("done_words_left", exp_q.size(), 32'd0);
            chk("done_after_last", {31'd0, prev_last_hs | zero_job}, 32'd1);
            done_armed = 1'b0;
            zero_job   = 1'b0;
            done_count++;
         end
         prev_valid   = sif.out_valid;
         prev_ready   = sif.out_ready;
         prev_data    = sif.out_data;
         prev_last_hs = sif.out_valid & sif.out_ready & sif.out_last;
      end
   end

   task automatic chk_idle_outputs(input string name);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_addr"}, {18'd0, ram_addr}, 32'd0);
      chk({name, "_data"}, {24'd0, sif.out_data}, 32'd0);
      chk({name, "_valid"}, {31'd0, sif.out_valid}, 32'd0);
      chk({name, "_last"}, {31'd0, sif.out_last}, 32'd0);
      chk({name, "_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int first_valid;
      int dc;
      logic [15:0] pat;
      for (int i = 0; i < CELLS; i++) tape[i] = 1'b0;

      // Reset defaults
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Zero-length request
      do_start(0, 0, 1'b1);
      @(negedge clk);
      chk("zero_done_c1", {31'd0, done}, 32'd1);
      chk("zero_busy_c1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("zero_done_c2", {31'd0, done}, 32'd0);
      chk("zero_busy_c2", {31'd0, busy}, 32'd0);
      chk("zero_no_words", cap_q.size(), 32'd0);

      // Full words, always ready
      pat = 16'b0000_1111_1000_1101;
      for (int i = 0; i < 16; i++) tape[i] = pat[i];
      ready_mode = 0;
      cap_q.delete();
      do_start(0, 16, 1'b1);
      chk("model_w0", {24'd0, exp_q[0]}, 32'h8D);
      chk("model_w1", {24'd0, exp_q[1]}, 32'h0F);
      first_valid = 0;
      for (int c = 1; c <= 40 && first_valid == 0; c++) begin
         @(negedge clk);
         if (sif.out_valid) first_valid = c;
      end
      chk("first_valid_cycle", first_valid, 32'd17);
      wait_done(100, "full_done");
      chk("full_words", cap_q.size(), 32'd2);
      if (cap_q.size() == 2) begin
         chk("full_w0", {24'd0, cap_q[0]}, 32'h8D);
         chk("full_w1", {24'd0, cap_q[1]}, 32'h0F);
      end

      // Partial word with address wrap
      tape[16382] = 1'b1; tape[16383] = 1'b1; tape[0] = 1'b1;
      cap_q.delete();
      do_start(16382, 3, 1'b1);
      @(negedge clk);
      chk("wrap_addr0", {18'd0, ram_addr}, 32'd16382);
      repeat (2) @(negedge clk);
      chk("wrap_addr1", {18'd0, ram_addr}, 32'd16383);
      repeat (2) @(negedge clk);
      chk("wrap_addr2", {18'd0, ram_addr}, 32'd0);
      wait_done(50, "wrap_done");
      chk("wrap_words", cap_q.size(), 32'd1);
      if (cap_q.size() == 1) chk("wrap_w0", {24'd0, cap_q[0]}, 32'h07);

      // Backpressure: ready low for 5 cycles once valid rises
      for (int i = 0; i < 8; i++) tape[200 + i] = 1'($urandom_range(0, 1));
      ready_mode = 2;
      sif.out_ready = 1'b0;
      cap_q.delete();
      do_start(200, 8, 1'b1);
      first_valid = 0;
      for (int c = 1; c <= 40 && first_valid == 0; c++) begin
         @(negedge clk);
         if (sif.out_valid) first_valid = c;
      end
      chk("bp_valid_seen", first_valid, 32'd17);
      repeat (5) @(posedge clk);
      #1 sif.out_ready = 1'b1;
      wait_done(20, "bp_done");
      chk("bp_words", cap_q.size(), 32'd1);
      ready_mode = 0;

      // Start while busy is ignored
      cap_q.delete();
      do_start(0, 16, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; base_addr = AW'(100); length = (AW + 1)'(5);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(100, "busy_start_done");
      chk("busy_start_words", cap_q.size(), 32'd2);
      repeat (30) @(negedge clk);
      chk("busy_start_idle", {31'd0, busy}, 32'd0);

      // Reset mid-run during the third word
      for (int i = 0; i < 40; i++) tape[300 + i] = 1'($urandom_range(0, 1));
      cap_q.delete();
      do_start(300, 24, 1'b1);
      for (int i = 0; i < 100 && cap_q.size() < 2; i++) begin
         @(negedge clk); #1;
      end
      chk("midrun_two_words", cap_q.size(), 32'd2);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      done_armed = 1'b0;
      dc = done_count;
      @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("midrun_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrun_no_done", done_count, dc);
      cap_q.delete();
      do_start(310, 10, 1'b1);
      wait_done(100, "after_rst_done");
      chk("after_rst_words", cap_q.size(), 32'd2);

      // Randomized jobs with random backpressure
      ready_mode = 1;
      for (int j = 0; j < 12; j++) begin
         for (int i = 0; i < CELLS; i++) tape[i] = 1'($urandom_range(0, 1));
         do_start(int'($urandom_range(0, CELLS - 1)), int'($urandom_range(0, 40)), 1'b1);
         wait_done(1000, "rand_done");
      end

      // Over-long length clamps to the whole tape
      ready_mode = 0;
      cap_q.delete();
      do_start(int'($urandom_range(0, CELLS - 1)), 32767, 1'b1);
      wait_done(40000, "clamp_done");
      chk("clamp_words", cap_q.size(), 32'd2048);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
